// File: rtl/udc_pkg.sv
// Shared definitions for the up/down counter command arbiter.
package udc_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        HOLD  = 2'd2
    } state_t;

    // Request direction encoding on dir0/dir1.
    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // Width of the holdoff value (HOLDOFF is limited to 1..15).
    localparam int HOLD_CNT_W = 4;

    // True when a command in direction dir would push the count past a limit.
    function automatic logic at_limit(input logic dir, input logic is_max, input logic is_min);
        return (dir == DIR_UP) ? is_max : is_min;
    endfunction

endpackage

// File: rtl/udc_holdoff_timer.sv
// Dead-time counter: after load, done rises once holdoff cycles have elapsed.
module udc_holdoff_timer
    import udc_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [HOLD_CNT_W-1:0] holdoff,
    output logic                  done
);

    logic [HOLD_CNT_W-1:0] cnt_reg;

    // Load holdoff-1 so done is seen in the last of holdoff cycles, then count down to zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= holdoff - 1'b1;
        end else if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = (cnt_reg == '0);

endmodule

// File: rtl/udc_arbiter.sv
// Two-requester arbiter issuing saturating up/down strobes to a counter datapath.
module udc_arbiter
    import udc_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MAX_VAL = 15,
    parameter int MIN_VAL = 0,
    parameter int HOLDOFF = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req0,
    input  logic             req1,
    input  logic             dir0,
    input  logic             dir1,
    output logic             ack0,
    output logic             ack1,
    output logic             rej,
    output logic             up,
    output logic             down,
    output logic [WIDTH-1:0] count,
    output logic             at_max,
    output logic             at_min,
    output logic             busy
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX_VAL);
    localparam logic [WIDTH-1:0] MIN_V = WIDTH'(MIN_VAL);

    state_t           state_reg, state_next;
    logic             grant_reg, grant_next;   // granted requester index
    logic             dir_reg, dir_next;       // latched direction of the grant
    logic             rr_reg, rr_next;         // requester favoured on a tie
    logic [WIDTH-1:0] count_reg, count_next;

    logic             pick;
    logic             is_max;
    logic             is_min;
    logic             limit_hit;
    logic             in_issue;
    logic             hold_load;
    logic             hold_done;
    logic [1:0]       ack_vec;

    assign is_max    = (count_reg == MAX_V);
    assign is_min    = (count_reg == MIN_V);
    assign limit_hit = at_limit(dir_reg, is_max, is_min);
    assign in_issue  = (state_reg == ISSUE);

    // Lone requester wins outright; a tie goes to the round-robin favourite.
    assign pick = (req0 && req1) ? rr_reg : req1;

    udc_holdoff_timer u_holdoff (
        .clk     (clk),
        .reset   (reset),
        .load    (hold_load),
        .holdoff (HOLD_CNT_W'(HOLDOFF)),
        .done    (hold_done)
    );

    // State and datapath registers; reset drops any step still in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            grant_reg <= 1'b0;
            dir_reg   <= DIR_DOWN;
            rr_reg    <= 1'b0;
            count_reg <= MIN_V;
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            dir_reg   <= dir_next;
            rr_reg    <= rr_next;
            count_reg <= count_next;
        end
    end

    // Next-state: grant in IDLE, apply the count step leaving ISSUE, wait out HOLD.
    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        dir_next   = dir_reg;
        rr_next    = rr_reg;
        count_next = count_reg;
        hold_load  = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req0 || req1) begin
                    grant_next = pick;
                    dir_next   = pick ? dir1 : dir0;
                    if (req0 && req1) begin
                        rr_next = ~rr_reg;
                    end
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                hold_load  = 1'b1;
                state_next = HOLD;
                if (!limit_hit) begin
                    count_next = (dir_reg == DIR_UP) ? count_reg + 1'b1 : count_reg - 1'b1;
                end
            end
            HOLD: begin
                if (hold_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One ack line per requester, pulsed during the ISSUE cycle of its grant.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_ack
            assign ack_vec[gi] = in_issue && (grant_reg == 1'(gi));
        end
    endgenerate

    assign ack0   = ack_vec[0];
    assign ack1   = ack_vec[1];
    assign rej    = in_issue && limit_hit;
    assign up     = in_issue && !limit_hit && (dir_reg == DIR_UP);
    assign down   = in_issue && !limit_hit && (dir_reg == DIR_DOWN);
    assign count  = count_reg;
    assign at_max = is_max;
    assign at_min = is_min;
    assign busy   = (state_reg != IDLE);

endmodule

// File: tb/tb_udc_arbiter.sv
// Self-checking bench for udc_arbiter: cycle model plus directed scenarios.
module tb_udc_arbiter;

    localparam int WIDTH   = 4;
    localparam int MAX_VAL = 15;
    localparam int MIN_VAL = 0;
    localparam int HOLDOFF = 3;

    logic             clk;
    logic             rst_n;
    logic             req0, req1, dir0, dir1;
    logic             ack0, ack1, rej, up, down;
    logic [WIDTH-1:0] count;
    logic             at_max, at_min, busy;

    int n_checks = 0;
    int n_fail   = 0;

    udc_arbiter #(
        .WIDTH   (WIDTH),
        .MAX_VAL (MAX_VAL),
        .MIN_VAL (MIN_VAL),
        .HOLDOFF (HOLDOFF)
    ) dut (
        .clk    (clk),
        .reset  (rst_n),
        .req0   (req0),
        .req1   (req1),
        .dir0   (dir0),
        .dir1   (dir1),
        .ack0   (ack0),
        .ack1   (ack1),
        .rej    (rej),
        .up     (up),
        .down   (down),
        .count  (count),
        .at_max (at_max),
        .at_min (at_min),
        .busy   (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The arbiter accepts a request at an edge only once the previous grant's
    // ISSUE + HOLDOFF dead cycles + one IDLE cycle have elapsed; the strobe
    // shows in the cycle after that edge and the count moves one edge later.
    int m_count, m_rr, m_edge, m_free, m_delta;
    bit e_ack0, e_ack1, e_rej, e_up, e_down, e_busy;

    initial begin
        m_count = MIN_VAL; m_rr = 0; m_edge = 0; m_free = 0; m_delta = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_count = MIN_VAL; m_rr = 0; m_edge = 0; m_free = 0; m_delta = 0;
                e_ack0 = 0; e_ack1 = 0; e_rej = 0; e_up = 0; e_down = 0; e_busy = 0;
            end else begin
                bit g, d;
                m_edge++;
                m_count += m_delta;
                m_delta = 0;
                e_ack0 = 0; e_ack1 = 0; e_rej = 0; e_up = 0; e_down = 0;
                if (m_edge >= m_free && (req0 || req1)) begin
                    if (req0 && req1) begin
                        g = (m_rr != 0);
                        m_rr = 1 - m_rr;
                    end else begin
                        g = req1;
                    end
                    d = g ? dir1 : dir0;
                    if (g) e_ack1 = 1; else e_ack0 = 1;
                    if ((d && m_count == MAX_VAL) || (!d && m_count == MIN_VAL)) begin
                        e_rej = 1;
                    end else if (d) begin
                        e_up = 1; m_delta = 1;
                    end else begin
                        e_down = 1; m_delta = -1;
                    end
                    m_free = m_edge + 2 + HOLDOFF;
                end
                e_busy = (m_edge < m_free - 1);
            end
        end
    end

    // Compare every output against the model on each falling edge.
    initial begin
        forever begin
            @(negedge clk);
            chk("ack0", int'(ack0), int'(e_ack0));
            chk("ack1", int'(ack1), int'(e_ack1));
            chk("rej", int'(rej), int'(e_rej));
            chk("up", int'(up), int'(e_up));
            chk("down", int'(down), int'(e_down));
            chk("busy", int'(busy), int'(e_busy));
            chk("count", int'(count), m_count);
            chk("at_max", int'(at_max), int'(m_count == MAX_VAL));
            chk("at_min", int'(at_min), int'(m_count == MIN_VAL));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0 = 0; req1 = 0; dir0 = 0; dir1 = 0;
        tick(2);
        rst_n = 1'b1;
    endtask

    // which: 0 = ack0, 1 = ack1, 2 = either
    task automatic wait_ack(input int which);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick(1);
            if ((which == 0 && ack0) || (which == 1 && ack1) || (which == 2 && (ack0 || ack1)))
                got = 1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL wait_ack%0d: got no ack in 20 cycles, expected an ack", which);
        end
    endtask

    initial begin
        int exp_ack0[4];
        int exp_cnt[4];
        int seen;
        exp_ack0 = '{1, 0, 1, 0};
        exp_cnt  = '{1, 0, 1, 0};

        rst_n = 1'b0;
        req0 = 0; req1 = 0; dir0 = 0; dir1 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", int'(busy), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_ack0", int'(ack0), 0);
        chk("rst_up", int'(up), 0);
        chk("rst_at_min", int'(at_min), 1);
        rst_n = 1'b1;

        // Single requester, held: strobe one cycle after the request, repeat 5 later.
        req0 = 1; dir0 = 1;
        tick(1);
        chk("s1_up", int'(up), 1);
        chk("s1_ack0", int'(ack0), 1);
        tick(1);
        chk("s1_count1", int'(count), 1);
        chk("s1_up_off", int'(up), 0);
        tick(4);
        chk("s1_up2", int'(up), 1);
        req0 = 0;
        tick(1);
        chk("s1_count2", int'(count), 2);
        tick(6);

        // Both requesters held: grants alternate, count 1,0,1,0.
        do_reset();
        req0 = 1; dir0 = 1; req1 = 1; dir1 = 0;
        for (int i = 0; i < 4; i++) begin
            tick(i == 0 ? 1 : 4);
            chk($sformatf("rr_ack0_%0d", i), int'(ack0), exp_ack0[i]);
            tick(1);
            chk($sformatf("rr_count_%0d", i), int'(count), exp_cnt[i]);
        end
        req0 = 0; req1 = 0;
        tick(6);

        // Saturate at MAX_VAL, then an up request is refused.
        do_reset();
        req0 = 1; dir0 = 1;
        tick(1);
        repeat (14) tick(5);
        req0 = 0;
        tick(1);
        chk("max_count", int'(count), 15);
        req1 = 1; dir1 = 1;
        wait_ack(1);
        chk("max_rej", int'(rej), 1);
        chk("max_up", int'(up), 0);
        req1 = 0;
        tick(1);
        chk("max_count_hold", int'(count), 15);
        chk("max_at_max", int'(at_max), 1);
        tick(5);

        // Down at MIN_VAL refused; following up request counts to 1.
        do_reset();
        req0 = 1; dir0 = 0;
        wait_ack(0);
        chk("min_rej", int'(rej), 1);
        chk("min_down", int'(down), 0);
        req0 = 0;
        tick(1);
        chk("min_count", int'(count), 0);
        chk("min_at_min", int'(at_min), 1);
        req0 = 1; dir0 = 1;
        wait_ack(0);
        chk("min_up", int'(up), 1);
        req0 = 0;
        tick(1);
        chk("min_count1", int'(count), 1);
        chk("min_at_min0", int'(at_min), 0);
        tick(5);

        // Reset in HOLD at count 7 clears immediately; next tie goes to requester 0.
        do_reset();
        req0 = 1; dir0 = 1;
        tick(1);
        repeat (6) tick(5);
        req0 = 0;
        tick(1);
        chk("ar_count7", int'(count), 7);
        chk("ar_busy", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("ar_count0", int'(count), 0);
        chk("ar_busy0", int'(busy), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        req0 = 1; dir0 = 1; req1 = 1; dir1 = 1;
        wait_ack(2);
        chk("ar_first_ack0", int'(ack0), 1);
        chk("ar_first_ack1", int'(ack1), 0);
        req0 = 0; req1 = 0;
        tick(6);

        // A one-cycle req during HOLD is never acknowledged.
        do_reset();
        req0 = 1; dir0 = 1;
        tick(1);
        req0 = 0;
        tick(1);
        req0 = 1;
        tick(1);
        req0 = 0;
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            tick(1);
            if (ack0) seen++;
        end
        chk("drop_acks", seen, 0);
        chk("drop_count", int'(count), 1);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
